// File: rtl/simd_pipe_ctrl.sv
// SIMD instruction sequencer: fetches and decodes instruction words, then moves them through a
// three-stage Load/Execute/Store control pipeline that advances once every STAGE_CYCLES clocks.
// Supports start/done, HALT with drain, external stall and read-after-write interlock.
module simd_pipe_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned OP_SEL_WIDTH = 3,
  parameter int unsigned STAGE_CYCLES = 2,
  parameter int unsigned INSTR_WIDTH  = 4 + 3 * ADDR_WIDTH + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic                    stall_i,
  output logic [ADDR_WIDTH-1:0]   instr_addr_o,
  input  logic [INSTR_WIDTH-1:0]  instr_rdata_i,
  output logic [ADDR_WIDTH-1:0]   a_addr_o,
  output logic [ADDR_WIDTH-1:0]   b_addr_o,
  output logic [OP_SEL_WIDTH-1:0] pe_op_o,
  output logic                    dot_prod_en_o,
  output logic                    shift_o,
  output logic [ADDR_WIDTH-1:0]   r_addr_o,
  output logic                    r_we_o,
  output logic                    r_select_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    hazard_o
);

  localparam int unsigned TickW = $clog2(STAGE_CYCLES);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  typedef struct packed {
    logic                    valid;
    logic                    write_en;
    logic                    r_select;
    logic                    dot_en;
    logic                    shift;
    logic [OP_SEL_WIDTH-1:0] pe_op;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [ADDR_WIDTH-1:0]   b_addr;
    logic [ADDR_WIDTH-1:0]   r_addr;
  } stage_t;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [TickW-1:0]      tick_q;
  stage_t                st_l_q, st_e_q, st_s_q;
  logic                  hazard_q;

  stage_t     dec;
  logic [3:0] opcode;
  logic       is_halt;
  logic       hazard_det;
  logic       tick_last;
  logic       stages_empty;
  logic       load_l;

  assign opcode       = instr_rdata_i[INSTR_WIDTH-1 -: 4];
  assign is_halt      = (opcode == 4'hF);
  assign tick_last    = (tick_q == TickW'(STAGE_CYCLES - 1));
  assign stages_empty = !st_l_q.valid && !st_e_q.valid && !st_s_q.valid;

  // Decode the fetched word; anything that is not a writing op decodes to a bubble.
  always_comb begin
    dec = '0;
    if (!opcode[3]) begin
      dec.valid    = 1'b1;
      dec.write_en = 1'b1;
      dec.pe_op    = OP_SEL_WIDTH'(opcode[2:0]);
    end else if (opcode == 4'h8) begin
      dec.valid    = 1'b1;
      dec.write_en = 1'b1;
      dec.r_select = 1'b1;
      dec.dot_en   = 1'b1;
      dec.pe_op    = OP_SEL_WIDTH'(3);
    end
    if (dec.valid) begin
      dec.a_addr = instr_rdata_i[3*ADDR_WIDTH -: ADDR_WIDTH];
      dec.b_addr = instr_rdata_i[2*ADDR_WIDTH -: ADDR_WIDTH];
      dec.r_addr = instr_rdata_i[ADDR_WIDTH -: ADDR_WIDTH];
      dec.shift  = instr_rdata_i[0];
    end
  end

  // Read-after-write check of the decoded operands against every in-flight writer.
  always_comb begin
    hazard_det = 1'b0;
    if (state_q == StRun && dec.valid) begin
      if (st_l_q.valid && st_l_q.write_en &&
          (st_l_q.r_addr == dec.a_addr || st_l_q.r_addr == dec.b_addr)) hazard_det = 1'b1;
      if (st_e_q.valid && st_e_q.write_en &&
          (st_e_q.r_addr == dec.a_addr || st_e_q.r_addr == dec.b_addr)) hazard_det = 1'b1;
      if (st_s_q.valid && st_s_q.write_en &&
          (st_s_q.r_addr == dec.a_addr || st_s_q.r_addr == dec.b_addr)) hazard_det = 1'b1;
    end
  end

  // NOPs still enter L (as bubbles) so pc moves past them.
  assign load_l = (state_q == StRun) && !is_halt && !hazard_det;

  // Sequencer FSM, tick counter, pc and pipeline stages; stall freezes all of it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      tick_q   <= '0;
      st_l_q   <= '0;
      st_e_q   <= '0;
      st_s_q   <= '0;
      hazard_q <= 1'b0;
    end else if (!stall_i) begin
      if (state_q == StIdle) begin
        if (start_i) begin
          state_q  <= StRun;
          pc_q     <= '0;
          tick_q   <= '0;
          st_l_q   <= '0;
          st_e_q   <= '0;
          st_s_q   <= '0;
          hazard_q <= 1'b0;
        end
      end else if (tick_last) begin
        tick_q   <= '0;
        hazard_q <= hazard_det;
        if (state_q == StDrain && stages_empty) begin
          state_q <= StIdle;
        end else begin
          st_s_q <= st_e_q;
          st_e_q <= st_l_q;
          if (load_l) begin
            st_l_q <= dec;
            pc_q   <= pc_q + ADDR_WIDTH'(1);
          end else begin
            st_l_q <= '0;
          end
          if (state_q == StRun && is_halt) state_q <= StDrain;
        end
      end else begin
        tick_q <= tick_q + TickW'(1);
      end
    end
  end

  assign instr_addr_o  = pc_q;
  assign a_addr_o      = st_l_q.a_addr;
  assign b_addr_o      = st_l_q.b_addr;
  assign pe_op_o       = st_e_q.pe_op;
  assign dot_prod_en_o = st_e_q.dot_en;
  assign shift_o       = st_e_q.shift;
  assign r_addr_o      = st_s_q.r_addr;
  assign r_select_o    = st_s_q.r_select;
  assign r_we_o        = st_s_q.valid && st_s_q.write_en && tick_last && !stall_i;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDrain) && tick_last && !stall_i && stages_empty;
  assign hazard_o      = hazard_q;

endmodule

// File: tb/tb_simd_pipe_ctrl.sv
// Testbench for simd_pipe_ctrl: directed programs plus randomized programs with random stalls,
// checked every cycle against an instruction-level pipeline model.
module tb_simd_pipe_ctrl;

  localparam int AW = 10;
  localparam int OW = 3;
  localparam int SC = 2;
  localparam int IW = 4 + 3 * AW + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [AW-1:0] instr_addr;
  logic [IW-1:0] instr_rdata = '0;
  logic [AW-1:0] a_addr, b_addr, r_addr;
  logic [OW-1:0] pe_op;
  logic          dot_prod_en, shift, r_we, r_select, busy, done, hazard;

  simd_pipe_ctrl #(
    .ADDR_WIDTH  (AW),
    .OP_SEL_WIDTH(OW),
    .STAGE_CYCLES(SC)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start),
    .stall_i      (stall),
    .instr_addr_o (instr_addr),
    .instr_rdata_i(instr_rdata),
    .a_addr_o     (a_addr),
    .b_addr_o     (b_addr),
    .pe_op_o      (pe_op),
    .dot_prod_en_o(dot_prod_en),
    .shift_o      (shift),
    .r_addr_o     (r_addr),
    .r_we_o       (r_we),
    .r_select_o   (r_select),
    .busy_o       (busy),
    .done_o       (done),
    .hazard_o     (hazard)
  );

  always #5 clk = ~clk;

  // Instruction BRAM with one-cycle read latency.
  logic [IW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) instr_rdata <= mem[instr_addr];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 run, 2 drain; stage 0 = L, 1 = E, 2 = S.
  int            m_st, m_pc, m_ph;
  bit            m_haz;
  bit            m_v [3];
  logic [IW-1:0] m_w [3];

  function automatic logic [IW-1:0] mk(input int op, input int a, input int b, input int r,
                                       input int sh);
    logic [3:0] o4 = 4'(op);
    logic [AW-1:0] a1 = AW'(a), b1 = AW'(b), r1 = AW'(r);
    logic s1 = sh[0];
    return {o4, a1, b1, r1, s1};
  endfunction

  function automatic logic [3:0]    f_op(input logic [IW-1:0] w); return w[IW-1 -: 4];   endfunction
  function automatic logic [AW-1:0] f_a (input logic [IW-1:0] w); return w[3*AW -: AW];  endfunction
  function automatic logic [AW-1:0] f_b (input logic [IW-1:0] w); return w[2*AW -: AW];  endfunction
  function automatic logic [AW-1:0] f_r (input logic [IW-1:0] w); return w[AW -: AW];    endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_ph = 0; m_haz = 0;
    for (int k = 0; k < 3; k++) begin m_v[k] = 0; m_w[k] = '0; end
  endtask

  task automatic model_advance();
    logic [IW-1:0] w;
    logic [3:0]    op;
    bit            enter, step, conflict;
    m_haz = 0;
    if (m_st == 2 && !m_v[0] && !m_v[1] && !m_v[2]) begin m_st = 0; return; end
    w = mem[m_pc]; op = f_op(w); enter = 0; step = 0;
    if (m_st == 1) begin
      if (op == 4'hF) m_st = 2;
      else if (op <= 4'h8) begin
        conflict = 0;
        for (int k = 0; k < 3; k++)
          if (m_v[k] && (f_r(m_w[k]) == f_a(w) || f_r(m_w[k]) == f_b(w))) conflict = 1;
        if (conflict) m_haz = 1;
        else begin enter = 1; step = 1; end
      end else step = 1;
    end
    m_w[2] = m_w[1]; m_v[2] = m_v[1];
    m_w[1] = m_w[0]; m_v[1] = m_v[0];
    m_w[0] = enter ? w : '0; m_v[0] = enter;
    if (step) m_pc = (m_pc + 1) % (1 << AW);
  endtask

  // Applies one clock edge to the model using the inputs that were held across it.
  task automatic model_clock();
    if (!rstn) begin model_reset(); return; end
    if (stall) return;
    if (m_st == 0) begin
      if (start) begin model_reset(); m_st = 1; end
      return;
    end
    if (m_ph == SC - 1) begin m_ph = 0; model_advance(); end
    else m_ph++;
  endtask

  task automatic check_all();
    logic [3:0] oe, os;
    bit         last;
    oe = f_op(m_w[1]); os = f_op(m_w[2]);
    last = (m_ph == SC - 1) && !stall && (m_st != 0);
    chk("busy", busy, m_st != 0);
    chk("instr_addr", instr_addr, m_pc);
    chk("a_addr", a_addr, m_v[0] ? f_a(m_w[0]) : '0);
    chk("b_addr", b_addr, m_v[0] ? f_b(m_w[0]) : '0);
    chk("pe_op", pe_op, !m_v[1] ? 0 : (oe < 8 ? oe[2:0] : 3));
    chk("dot_prod_en", dot_prod_en, m_v[1] && oe == 4'h8);
    chk("shift", shift, m_v[1] && m_w[1][0]);
    chk("r_addr", r_addr, m_v[2] ? f_r(m_w[2]) : '0);
    chk("r_select", r_select, m_v[2] && os == 4'h8);
    chk("r_we", r_we, m_v[2] && last);
    chk("done", done, m_st == 2 && last && !m_v[0] && !m_v[1] && !m_v[2]);
    chk("hazard", hazard, m_haz);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < (1 << AW); i++) mem[i] = mk(15, 0, 0, 0, 0);
  endtask

  // Starts the program in mem and runs it to idle; cycle 0 is the cycle after the start edge.
  task automatic run_prog(input int stall_pct, input int stall_from, input int stall_len,
                          input int abort_at, output int n_we, output int first_we,
                          output int second_we, output int n_done, output int sel_at_we);
    int cyc;
    bit finished;
    n_we = 0; first_we = -1; second_we = -1; n_done = 0; sel_at_we = -1;
    @(negedge clk); start = 1'b1; stall = 1'b0;
    #1 check_all();
    @(posedge clk); model_clock();
    cyc = 0; finished = 0;
    while (!finished) begin
      @(negedge clk);
      start = 1'b0;
      stall = (cyc >= stall_from && cyc < stall_from + stall_len) ||
              (stall_pct > 0 && int'($urandom_range(99)) < stall_pct);
      if (cyc == abort_at) rstn = 1'b0;
      #1 check_all();
      if (r_we) begin
        if (n_we == 0) begin first_we = cyc; sel_at_we = int'(r_select); end
        else if (n_we == 1) second_we = cyc;
        n_we++;
      end
      if (done) n_done++;
      @(posedge clk); model_clock();
      cyc++;
      if (m_st == 0) finished = 1;
      else if (cyc >= 3000) begin
        n_tests++; n_fail++;
        $display("FAIL timeout busy=%0b required idle", busy);
        finished = 1;
      end
    end
    @(negedge clk); stall = 1'b0; rstn = 1'b1;
    #1 check_all();
  endtask

  initial begin
    int nw, fw, sw, nd, sel;
    int len, op;
    clear_mem();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check_all();
    rstn = 1'b1;

    // Three independent ADDs then HALT.
    clear_mem();
    mem[0] = mk(0, 1, 2, 10, 0); mem[1] = mk(0, 3, 4, 11, 0); mem[2] = mk(0, 6, 7, 12, 1);
    run_prog(0, -1, 0, -1, nw, fw, sw, nd, sel);
    chk("adds_n_we", nw, 3);
    chk("adds_first_we", fw, 4 * SC - 1);
    chk("adds_second_we", sw, 4 * SC - 1 + SC);
    chk("adds_done", nd, 1);

    // RAW hazard: SUB reads ADD's result address.
    clear_mem();
    mem[0] = mk(0, 1, 2, 5, 0); mem[1] = mk(1, 5, 3, 6, 0);
    run_prog(0, -1, 0, -1, nw, fw, sw, nd, sel);
    chk("haz_n_we", nw, 2);
    chk("haz_we_gap", sw - fw, 4 * SC);

    // DOT with shift.
    clear_mem();
    mem[0] = mk(8, 1, 2, 20, 1);
    run_prog(0, -1, 0, -1, nw, fw, sw, nd, sel);
    chk("dot_n_we", nw, 1);
    chk("dot_r_select", sel, 1);

    // Five-cycle stall mid-program shifts the sequence by five cycles.
    clear_mem();
    mem[0] = mk(0, 1, 2, 10, 0); mem[1] = mk(0, 3, 4, 11, 0); mem[2] = mk(0, 6, 7, 12, 1);
    run_prog(0, 3, 5, -1, nw, fw, sw, nd, sel);
    chk("stall_n_we", nw, 3);
    chk("stall_first_we", fw, 4 * SC - 1 + 5);

    // Undefined opcode acts as a NOP.
    clear_mem();
    mem[0] = mk(9, 1, 2, 3, 0);
    run_prog(0, -1, 0, -1, nw, fw, sw, nd, sel);
    chk("nop_n_we", nw, 0);
    chk("nop_done", nd, 1);

    // Reset in the middle of RUN, then re-execute from pc 0.
    clear_mem();
    mem[0] = mk(0, 1, 2, 10, 0); mem[1] = mk(0, 3, 4, 11, 0); mem[2] = mk(0, 6, 7, 12, 1);
    run_prog(0, -1, 0, 5, nw, fw, sw, nd, sel);
    chk("abort_done", nd, 0);
    chk("abort_busy", busy, 0);
    run_prog(0, -1, 0, -1, nw, fw, sw, nd, sel);
    chk("rerun_n_we", nw, 3);
    chk("rerun_first_we", fw, 4 * SC - 1);

    // Random programs with random stalls; small address range to provoke hazards.
    for (int p = 0; p < 20; p++) begin
      clear_mem();
      len = int'($urandom_range(12, 3));
      for (int i = 0; i < len; i++) begin
        op = int'($urandom_range(15));
        if (op == 15 && i < 2) op = 10;
        mem[i] = mk(op, $urandom_range(7), $urandom_range(7), $urandom_range(7),
                    $urandom_range(1));
      end
      run_prog(15, -1, 0, -1, nw, fw, sw, nd, sel);
      chk("rand_done", nd, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
